wb_sdram_arbiter: RTL and testbench

WB_SDRAM_ARBITER -- requirements
Module: wb_sdram_arbiter

---
 rtl/wb_sdram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_wb_sdram_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter: NM Wishbone B4 pipelined masters onto one SDRAM port.
// Define WB_SDRAM_ARB_RR_EN for round-robin; default is fixed priority.
module wb_sdram_arbiter #(
   parameter int AW     = 24,
   parameter int DW     = 16,
   parameter int NM     = 2,
   parameter int MAXOUT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NM-1:0]          m_cyc_i,
   input  logic [NM-1:0]          m_stb_i,
   input  logic [NM-1:0]          m_we_i,
   input  logic [NM*AW-1:0]       m_adr_i,
   input  logic [NM*DW-1:0]       m_dat_i,
   input  logic [NM*(DW/8)-1:0]   m_sel_i,
   output logic [DW-1:0]          m_dat_o,
   output logic [NM-1:0]          m_ack_o,
   output logic [NM-1:0]          m_stall_o,
   output logic                   s_cyc_o,
   output logic                   s_stb_o,
   output logic                   s_we_o,
   output logic [AW-1:0]          s_adr_o,
   output logic [DW-1:0]          s_dat_o,
   output logic [DW/8-1:0]        s_sel_o,
   input  logic [DW-1:0]          s_dat_i,
   input  logic                   s_ack_i,
   input  logic                   s_stall_i
);

   localparam int OW = (NM > 1) ? $clog2(NM) : 1;
   localparam int CW = $clog2(MAXOUT + 1);
   localparam int SW = DW / 8;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [CW-1:0] CMAX = CW'(MAXOUT);
   localparam logic [CW-1:0] CONE = CW'(1);

   logic [1:0]    state;
   logic [1:0]    state_nx;
   logic [OW-1:0] owner;
   logic [OW-1:0] winner;
   logic [CW-1:0] outstanding;
   logic          full;
   logic          inc;
   logic          dec;
   logic          any_req;
   logic          own_cyc;
   logic          own_stb;
   logic          empty_nx;

   assign full     = (outstanding == CMAX);
   assign any_req  = |m_cyc_i;
   assign inc      = s_stb_o & ~s_stall_i;
   assign dec      = s_ack_i & (outstanding != '0);
   assign empty_nx = (outstanding == '0) ||
                     ((outstanding == CONE) && s_ack_i);
   assign m_dat_o  = s_dat_i;

`ifdef WB_SDRAM_ARB_RR_EN
   logic [OW-1:0] last;

   // Round-robin pick: first requester after the previous winner.
   always_comb begin
      logic found;
      found  = 1'b0;
      winner = last;
      for (int k = 1; k <= NM; k++) begin
         if (!found && m_cyc_i[(int'(last) + k) % NM]) begin
            winner = OW'((int'(last) + k) % NM);
            found  = 1'b1;
         end
      end
   end

   // Remember the winner of every grant.
   always_ff @(posedge clk) begin
      if (!rst_n)
         last <= OW'(NM - 1);
      else if (state == IDLE && any_req)
         last <= winner;
   end
`else
   // Fixed priority pick: lowest requesting index.
   always_comb begin
      logic found;
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < NM; i++) begin
         if (!found && m_cyc_i[i]) begin
            winner = OW'(i);
            found  = 1'b1;
         end
      end
   end
`endif

   // Steer the owner's request onto the downstream port.
   always_comb begin
      own_cyc = 1'b0;
      own_stb = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      for (int i = 0; i < NM; i++) begin
         if (owner == OW'(i)) begin
            own_cyc = m_cyc_i[i];
            own_stb = m_stb_i[i];
            s_we_o  = m_we_i[i];
            s_adr_o = m_adr_i[i*AW +: AW];
            s_dat_o = m_dat_i[i*DW +: DW];
            s_sel_o = m_sel_i[i*SW +: SW];
         end
      end
   end

   // Handshake outputs per state; non-owners always stall.
   always_comb begin
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      m_ack_o   = '0;
      m_stall_o = '1;
      case (state)
         GRANT: begin
            s_cyc_o = own_cyc;
            s_stb_o = own_stb & ~full;
            for (int i = 0; i < NM; i++) begin
               if (owner == OW'(i)) begin
                  m_stall_o[i] = s_stall_i | full;
                  m_ack_o[i]   = s_ack_i;
               end
            end
         end
         DRAIN: s_cyc_o = 1'b1;
         default: ;
      endcase
   end

   // Next state; leave GRANT/DRAIN once nothing remains in flight.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:
            if (any_req) state_nx = GRANT;
         GRANT:
            if (!own_cyc) state_nx = empty_nx ? IDLE : DRAIN;
         DRAIN:
            if (empty_nx) state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   // State and owner registers; owner only latches in IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         owner <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && any_req)
            owner <= winner;
      end
   end

   // Outstanding request count; acks with nothing in flight are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n)
         outstanding <= '0;
      else if (inc && !dec)
         outstanding <= outstanding + CONE;
      else if (dec && !inc)
         outstanding <= outstanding - CONE;
   end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// tb_wb_sdram_arbiter: scoreboarded bench for wb_sdram_arbiter.
// Honors WB_SDRAM_ARB_RR_EN for the expected grant order.
module tb_wb_sdram_arbiter;

   localparam int AW = 24;
   localparam int DW = 16;
   localparam int NM = 2;
   localparam int MO = 4;
   localparam int SW = DW / 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NM-1:0]     m_cyc = '0;
   logic [NM-1:0]     m_stb = '0;
   logic [NM-1:0]     m_we = '0;
   logic [NM*AW-1:0]  m_adr = '0;
   logic [NM*DW-1:0]  m_dat = '0;
   logic [NM*SW-1:0]  m_sel = '0;
   logic [DW-1:0]     m_dat_o;
   logic [NM-1:0]     m_ack_o;
   logic [NM-1:0]     m_stall_o;
   logic              s_cyc_o;
   logic              s_stb_o;
   logic              s_we_o;
   logic [AW-1:0]     s_adr_o;
   logic [DW-1:0]     s_dat_o;
   logic [SW-1:0]     s_sel_o;
   logic [DW-1:0]     s_dat_i = '0;
   logic              s_ack_i = 1'b0;
   logic              s_stall_i = 1'b0;

   wb_sdram_arbiter #(
      .AW(AW), .DW(DW), .NM(NM), .MAXOUT(MO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
      .m_stall_o(m_stall_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_stall_i(s_stall_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            id;
      logic [AW-1:0] adr;
      logic          we;
      logic [DW-1:0] dat;
      logic [SW-1:0] sel;
   } req_t;

   req_t expq[$];
   int   pendq[$];
   int   errors = 0;
   int   checks = 0;
   bit   sb_on = 1'b0;

   int            nb   [NM];
   int            blen [NM][4];
   logic [AW-1:0] badr [NM][4][4];
   logic          bwe  [NM][4][4];
   logic [DW-1:0] bdat [NM][4][4];
   logic [SW-1:0] bsel [NM][4][4];

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h",
                  name, act, exp);
      end
   endtask

   task automatic gen(input int fixlen, input int wemode);
      logic [AW-1:0] a;
      for (int i = 0; i < NM; i++)
         for (int b = 0; b < 4; b++) begin
            blen[i][b] = fixlen > 0 ? fixlen
                                    : int'($urandom_range(4, 1));
            for (int r = 0; r < 4; r++) begin
               a = AW'($urandom);
               a[7:0] = 8'(i * 16 + b * 4 + r);
               badr[i][b][r] = a;
               bwe[i][b][r]  = wemode == 2 ? 1'($urandom)
                                           : (wemode == 1);
               bdat[i][b][r] = DW'($urandom);
               bsel[i][b][r] = SW'($urandom);
            end
         end
   endtask

   // Expected downstream order: whole bursts, owner by arbitration rule.
   task automatic build_model();
      int   rem [NM];
      int   lst;
      int   pick;
      int   b;
      req_t e;
      expq.delete();
      pendq.delete();
      lst = NM - 1;
      for (int i = 0; i < NM; i++) rem[i] = nb[i];
      while (1) begin
         pick = -1;
`ifdef WB_SDRAM_ARB_RR_EN
         for (int k = 1; k <= NM; k++)
            if (pick < 0 && rem[(lst + k) % NM] > 0)
               pick = (lst + k) % NM;
`else
         for (int i = 0; i < NM; i++)
            if (pick < 0 && rem[i] > 0) pick = i;
`endif
         if (pick < 0) break;
         lst = pick;
         b = nb[pick] - rem[pick];
         rem[pick]--;
         for (int r = 0; r < blen[pick][b]; r++) begin
            e.id  = pick;
            e.adr = badr[pick][b][r];
            e.we  = bwe[pick][b][r];
            e.dat = bdat[pick][b][r];
            e.sel = bsel[pick][b][r];
            expq.push_back(e);
         end
      end
   endtask

   // Scoreboard monitor: pops on every downstream accept and ack.
   initial begin
      req_t e;
      int   id;
      forever begin
         @(negedge clk);
         #1;
         if (sb_on) begin
            if (s_ack_i || m_ack_o != '0) begin
               if (pendq.size() == 0) begin
                  chk("ack_unexpected", 64'(m_ack_o), 64'(0));
               end else begin
                  id = pendq.pop_front();
                  chk("ack_route", 64'(m_ack_o), 64'(1 << id));
                  chk("ack_data", 64'(m_dat_o), 64'(s_dat_i));
               end
            end
            if (s_cyc_o && s_stb_o && !s_stall_i) begin
               if (expq.size() == 0) begin
                  chk("req_unexpected", 64'(s_adr_o), 64'(0));
               end else begin
                  e = expq.pop_front();
                  chk("req_adr", 64'(s_adr_o), 64'(e.adr));
                  chk("req_we", 64'(s_we_o), 64'(e.we));
                  chk("req_dat", 64'(s_dat_o), 64'(e.dat));
                  chk("req_sel", 64'(s_sel_o), 64'(e.sel));
                  pendq.push_back(e.id);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      tick();
      rst_n = 1'b0;
      m_cyc = '0;
      m_stb = '0;
      s_ack_i = 1'b0;
      s_stall_i = 1'b0;
      @(posedge clk);
      tick();
      rst_n = 1'b1;
   endtask

   task automatic count_stb(input int k, output int n);
      n = 0;
      for (int c = 0; c < k; c++) begin
         @(negedge clk);
         if (s_stb_o && !s_stall_i) n++;
         tick();
      end
   endtask

   // Master BFMs plus a latency-queue slave, one cycle per iteration.
   task automatic run_eng(input int stall_pct,
                          input int lat_lo, input int lat_hi);
      int ph [NM];
      int bi [NM];
      int ri [NM];
      int ai [NM];
      int dueq[$];
      int last_due;
      int cyc_n;
      int d;
      bit alldone;
      build_model();
      for (int i = 0; i < NM; i++) begin
         ph[i] = nb[i] > 0 ? 0 : 2;
         bi[i] = 0;
         ri[i] = 0;
         ai[i] = 0;
      end
      last_due = 0;
      cyc_n = 0;
      alldone = 1'b0;
      sb_on = 1'b1;
      while (!alldone && cyc_n < 4000) begin
         tick();
         cyc_n++;
         s_ack_i = 1'b0;
         s_dat_i = DW'($urandom);
         if (dueq.size() > 0 && dueq[0] <= cyc_n) begin
            s_ack_i = 1'b1;
            void'(dueq.pop_front());
         end
         s_stall_i = int'($urandom_range(99)) < stall_pct;
         for (int i = 0; i < NM; i++) begin
            m_cyc[i] = ph[i] == 0;
            m_stb[i] = ph[i] == 0 && ri[i] < blen[i][bi[i]];
            if (m_stb[i]) begin
               m_adr[i*AW +: AW] = badr[i][bi[i]][ri[i]];
               m_we[i]           = bwe[i][bi[i]][ri[i]];
               m_dat[i*DW +: DW] = bdat[i][bi[i]][ri[i]];
               m_sel[i*SW +: SW] = bsel[i][bi[i]][ri[i]];
            end
         end
         @(negedge clk);
         if (s_cyc_o && s_stb_o && !s_stall_i) begin
            d = cyc_n + int'($urandom_range(lat_hi, lat_lo));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            dueq.push_back(d);
         end
         alldone = 1'b1;
         for (int i = 0; i < NM; i++) begin
            if (ph[i] == 0) begin
               if (m_stb[i] && !m_stall_o[i]) ri[i]++;
               if (m_ack_o[i]) ai[i]++;
               if (ri[i] == blen[i][bi[i]] &&
                   ai[i] == blen[i][bi[i]])
                  ph[i] = 1;
            end else if (ph[i] == 1) begin
               if (stall_pct == 0)
                  chk("drop_cycle_grant", 64'(m_stall_o[i]), 64'(0));
               bi[i]++;
               ri[i] = 0;
               ai[i] = 0;
               ph[i] = bi[i] < nb[i] ? 0 : 2;
            end
            if (ph[i] != 2) alldone = 1'b0;
         end
      end
      if (!alldone) chk("engine_timeout", 64'(cyc_n), 64'(0));
      tick();
      m_cyc = '0;
      m_stb = '0;
      s_ack_i = 1'b0;
      s_stall_i = 1'b0;
      @(negedge clk);
      chk("idle_scyc", 64'(s_cyc_o), 64'(0));
      chk("idle_stall", 64'(m_stall_o), 64'({NM{1'b1}}));
      #2;
      sb_on = 1'b0;
      chk("expq_left", 64'(expq.size()), 64'(0));
      chk("pendq_left", 64'(pendq.size()), 64'(0));
   endtask

   initial begin
      int n;
      logic [AW-1:0] a1;

      rst_n = 1'b0;
      m_cyc = '1;
      m_stb = '1;
      s_ack_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_scyc", 64'(s_cyc_o), 64'(0));
      chk("rst_sstb", 64'(s_stb_o), 64'(0));
      chk("rst_ack", 64'(m_ack_o), 64'(0));
      chk("rst_stall", 64'(m_stall_o), 64'({NM{1'b1}}));

      nb[0] = 1;
      nb[1] = 0;
      gen(4, 0);
      reset_dut();
      run_eng(0, 3, 3);

      nb[0] = 2;
      nb[1] = 2;
      gen(2, 1);
      reset_dut();
      run_eng(0, 1, 2);

      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < NM; i++)
            nb[i] = int'($urandom_range(3, 1));
         gen(0, 2);
         reset_dut();
         run_eng(25, 1, 4);
      end

      reset_dut();
      m_cyc = 2'b01;
      m_stb = 2'b01;
      count_stb(8, n);
      chk("full_accepts", 64'(n), 64'(MO));
      @(negedge clk);
      chk("full_stall", 64'(m_stall_o), 64'(2'b11));
      chk("full_sstb", 64'(s_stb_o), 64'(0));
      tick();
      s_ack_i = 1'b1;
      @(negedge clk);
      chk("full_ack", 64'(m_ack_o), 64'(2'b01));
      tick();
      s_ack_i = 1'b0;
      count_stb(5, n);
      chk("full_release_one", 64'(n), 64'(1));

      reset_dut();
      a1 = 24'hABCDE1;
      m_adr[AW +: AW] = a1;
      m_cyc = 2'b11;
      m_stb = 2'b01;
      count_stb(3, n);
      chk("drain_accepts", 64'(n), 64'(2));
      m_cyc = 2'b10;
      m_stb = 2'b00;
      @(negedge clk);
      chk("drop_m1_stall", 64'(m_stall_o[1]), 64'(1));
      tick();
      @(negedge clk);
      chk("drain_scyc", 64'(s_cyc_o), 64'(1));
      chk("drain_sstb", 64'(s_stb_o), 64'(0));
      for (int k = 0; k < 2; k++) begin
         tick();
         s_ack_i = 1'b1;
         @(negedge clk);
         chk("drain_noack", 64'(m_ack_o), 64'(0));
         chk("drain_hold", 64'(s_cyc_o), 64'(1));
      end
      tick();
      s_ack_i = 1'b0;
      @(negedge clk);
      chk("drain_idle", 64'(m_stall_o), 64'(2'b11));
      chk("drain_idle_cyc", 64'(s_cyc_o), 64'(0));
      tick();
      @(negedge clk);
      chk("m1_grant_stall", 64'(m_stall_o), 64'(2'b01));
      chk("m1_grant_cyc", 64'(s_cyc_o), 64'(1));
      chk("m1_grant_adr", 64'(s_adr_o), 64'(a1));

      reset_dut();
      m_cyc = 2'b01;
      m_stb = 2'b01;
      count_stb(4, n);
      chk("pre_rst_accepts", 64'(n), 64'(3));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      s_ack_i = 1'b1;
      m_cyc = '0;
      m_stb = '0;
      @(negedge clk);
      chk("midrst_scyc", 64'(s_cyc_o), 64'(0));
      chk("midrst_sstb", 64'(s_stb_o), 64'(0));
      chk("midrst_stall", 64'(m_stall_o), 64'(2'b11));
      chk("midrst_ack", 64'(m_ack_o), 64'(0));
      tick();
      s_ack_i = 1'b0;
      m_cyc = 2'b01;
      m_stb = 2'b01;
      count_stb(8, n);
      chk("post_rst_accepts", 64'(n), 64'(MO));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
